// File: rtl/pkt_deframer_if.sv
// Framed input and payload output streams of pkt_deframer.
// master = upstream packer side, slave = deframer side.
interface pkt_deframer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  validIn;
  logic                  lastIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  validOut;
  logic                  lastOut;

  modport master (
    output dataIn,
    output validIn,
    output lastIn,
    input  dataOut,
    input  validOut,
    input  lastOut
  );

  modport slave (
    input  dataIn,
    input  validIn,
    input  lastIn,
    output dataOut,
    output validOut,
    output lastOut
  );
endinterface

// File: rtl/pkt_deframer.sv
// Header/footer deframer: checks sync, length and XOR footer, forwards payload.
// Optional macro PKT_DEFRAMER_STATS_EN adds good/bad packet counters.
module pkt_deframer #(
  parameter int          DATA_WIDTH = 32,
  parameter int          MAX_LEN    = 382,
  parameter logic [15:0] SYNC_WORD  = 16'hA5A5
) (
  input  logic        clock,
  input  logic        reset,
  pkt_deframer_if.slave bus,
  output logic        pktDone,
  output logic        hdrErr,
  output logic        lenErr,
  output logic        chkErr
`ifdef PKT_DEFRAMER_STATS_EN
  ,
  output logic [15:0] goodCnt,
  output logic [15:0] badCnt
`endif
);

  localparam logic [15:0] MAX_PAY = 16'(MAX_LEN - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_FOOTER,
    S_DISCARD
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] chk_q, chk_d;

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vout_q, vout_d;
  logic                  lout_q, lout_d;
  logic                  done_q, done_d;
  logic                  herr_q, herr_d;
  logic                  lerr_q, lerr_d;
  logic                  cerr_q, cerr_d;

  logic [15:0]           hdr_len;
  logic                  sync_ok;
  logic                  len_ok;
  logic                  hdr_ok;
  logic [15:0]           cnt_inc;
  logic [DATA_WIDTH-1:0] chk_nxt;

  assign hdr_len = bus.dataIn[15:0];
  assign sync_ok = (bus.dataIn[31:16] == SYNC_WORD);
  assign len_ok  = (hdr_len >= 16'd1) && (hdr_len <= MAX_PAY);
  assign hdr_ok  = sync_ok && len_ok;
  assign cnt_inc = cnt_q + 16'd1;
  assign chk_nxt = chk_q ^ bus.dataIn;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      lout_q  <= 1'b0;
      done_q  <= 1'b0;
      herr_q  <= 1'b0;
      lerr_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      lout_q  <= lout_d;
      done_q  <= done_d;
      herr_q  <= herr_d;
      lerr_q  <= lerr_d;
      cerr_q  <= cerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    lout_d  = 1'b0;
    done_d  = 1'b0;
    herr_d  = 1'b0;
    lerr_d  = 1'b0;
    cerr_d  = 1'b0;
    if (bus.validIn) begin
      unique case (state_q)
        S_IDLE: begin
          if (!hdr_ok) begin
            herr_d  = 1'b1;
            done_d  = 1'b1;
            state_d = bus.lastIn ? S_IDLE : S_DISCARD;
          end else if (bus.lastIn) begin
            lerr_d = 1'b1;
            done_d = 1'b1;
          end else begin
            len_d   = hdr_len;
            cnt_d   = '0;
            chk_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          vout_d = 1'b1;
          dout_d = bus.dataIn;
          chk_d  = chk_nxt;
          cnt_d  = cnt_inc;
          // An early lastIn wins even on the Lth word: the footer is missing.
          if (bus.lastIn) begin
            lout_d  = 1'b1;
            lerr_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_inc == len_q) begin
            lout_d  = 1'b1;
            state_d = S_FOOTER;
          end
        end
        S_FOOTER: begin
          done_d = 1'b1;
          cerr_d = (bus.dataIn != chk_q);
          if (bus.lastIn) begin
            state_d = S_IDLE;
          end else begin
            lerr_d  = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (bus.lastIn) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.dataOut  = dout_q;
  assign bus.validOut = vout_q;
  assign bus.lastOut  = lout_q;
  assign pktDone      = done_q;
  assign hdrErr       = herr_q;
  assign lenErr       = lerr_q;
  assign chkErr       = cerr_q;

`ifdef PKT_DEFRAMER_STATS_EN
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;
  logic        any_err;

  assign any_err = herr_q | lerr_q | cerr_q;

  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (done_q) begin
      if (any_err) begin
        if (bad_q != 16'hFFFF) begin
          bad_d = bad_q + 16'd1;
        end
      end else if (good_q != 16'hFFFF) begin
        good_d = good_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign goodCnt = good_q;
  assign badCnt  = bad_q;
`endif

endmodule

// File: tb/tb_pkt_deframer.sv
// Directed and random packets against a per-packet reference model.
// Define PKT_DEFRAMER_STATS_EN to also check the packet counters.
module tb_pkt_deframer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pkt_deframer_if #(.DATA_WIDTH(32)) bus ();
  logic pktDone, hdrErr, lenErr, chkErr;
`ifdef PKT_DEFRAMER_STATS_EN
  logic [15:0] goodCnt, badCnt;
`endif

  pkt_deframer dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .pktDone (pktDone),
    .hdrErr  (hdrErr),
    .lenErr  (lenErr),
    .chkErr  (chkErr)
`ifdef PKT_DEFRAMER_STATS_EN
    ,
    .goodCnt (goodCnt),
    .badCnt  (badCnt)
`endif
  );

  localparam logic [5:0] F_V = 6'b100000;
  localparam logic [5:0] F_L = 6'b010000;
  localparam logic [5:0] F_D = 6'b001000;
  localparam logic [5:0] F_H = 6'b000100;
  localparam logic [5:0] F_N = 6'b000010;
  localparam logic [5:0] F_C = 6'b000001;

  localparam int K_GOOD    = 0;
  localparam int K_BADCHK  = 1;
  localparam int K_SYNC    = 2;
  localparam int K_LEN     = 3;
  localparam int K_EARLY   = 4;
  localparam int K_NOLAST  = 5;
  localparam int K_HDRLAST = 6;

  int errors = 0;
  int checks = 0;
  int exp_good = 0;
  int exp_bad = 0;
  bit gap_en = 1'b0;
  logic [31:0] pl_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] d, input logic v, input logic l,
                      input logic [5:0] ef, input logic [31:0] ed);
    bus.dataIn  = d;
    bus.validIn = v;
    bus.lastIn  = l;
    @(posedge clock);
    #1;
    check("flags", {26'd0, bus.validOut, bus.lastOut, pktDone,
                    hdrErr, lenErr, chkErr}, {26'd0, ef});
    if (ef[5]) check("data", bus.dataOut, ed);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step($urandom, 1'b0, 1'($urandom_range(1)), 6'd0, 32'd0);
  endtask

  task automatic gap();
    if (gap_en && $urandom_range(3) == 0) idle(1);
  endtask

  task automatic rst_cycles(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step($urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
           6'd0, 32'd0);
      check("rst_data", bus.dataOut, 32'd0);
    end
    reset = 1'b0;
    exp_good = 0;
    exp_bad = 0;
  endtask

  task automatic check_stats();
`ifdef PKT_DEFRAMER_STATS_EN
    idle(2);
    check("goodCnt", {16'd0, goodCnt}, 32'(exp_good));
    check("badCnt", {16'd0, badCnt}, 32'(exp_bad));
`endif
  endtask

  // len is the header length field; k is early-last position or trailing count.
  task automatic send_pkt(input int kind, input int len, input int k);
    logic [31:0] x;
    logic [5:0]  fl;
    logic        lf;
    int          n;
    x = 32'd0;
    if (pl_q.size() == 0)
      for (int i = 0; i < len && i < 400; i++) pl_q.push_back($urandom);
    foreach (pl_q[i]) x ^= pl_q[i];
    if (kind == K_SYNC || kind == K_LEN) begin
      step({(kind == K_SYNC) ? 16'h1234 : 16'hA5A5, 16'(len)}, 1'b1,
           (k == 0), F_D | F_H, 32'd0);
      for (int i = 0; i < k; i++) begin
        gap();
        step($urandom, 1'b1, (i == k - 1), 6'd0, 32'd0);
      end
    end else if (kind == K_HDRLAST) begin
      step({16'hA5A5, 16'(len)}, 1'b1, 1'b1, F_D | F_N, 32'd0);
    end else begin
      step({16'hA5A5, 16'(len)}, 1'b1, 1'b0, 6'd0, 32'd0);
      n = (kind == K_EARLY) ? k : len;
      for (int i = 0; i < n; i++) begin
        gap();
        lf = (kind == K_EARLY) && (i == n - 1);
        fl = F_V;
        if (lf || i == len - 1) fl |= F_L;
        if (lf) fl |= F_D | F_N;
        step(pl_q[i], 1'b1, lf, fl, pl_q[i]);
      end
      if (kind != K_EARLY) begin
        gap();
        fl = F_D;
        if (kind == K_BADCHK) fl |= F_C;
        if (kind == K_NOLAST) fl |= F_N;
        step((kind == K_BADCHK) ? (x ^ 32'd1) : x, 1'b1,
             (kind != K_NOLAST), fl, 32'd0);
        if (kind == K_NOLAST)
          for (int i = 0; i < k; i++) begin
            gap();
            step($urandom, 1'b1, (i == k - 1), 6'd0, 32'd0);
          end
      end
    end
    if (kind == K_GOOD) exp_good++;
    else exp_bad++;
    pl_q.delete();
  endtask

  initial begin
    int kind, len, k;
    reset = 1'b1;
    bus.dataIn = '0;
    bus.validIn = 1'b0;
    bus.lastIn = 1'b0;
    rst_cycles(2);
    check_stats();

    pl_q = '{32'd1, 32'd2, 32'd4};
    send_pkt(K_GOOD, 3, 0);
    pl_q = '{32'd1, 32'd2, 32'd4};
    send_pkt(K_BADCHK, 3, 0);
    send_pkt(K_SYNC, 3, 4);
    send_pkt(K_GOOD, 1, 0);
    send_pkt(K_EARLY, 5, 3);
    send_pkt(K_GOOD, 4, 0);
    check_stats();

    send_pkt(K_GOOD, 380, 0);
    for (int p = 0; p < 100; p++) begin
      idle($urandom_range(0, 3));
      send_pkt(K_GOOD, 380, 0);
    end
    send_pkt(K_LEN, 381, 2);
    send_pkt(K_LEN, 0, 0);
    send_pkt(K_HDRLAST, 2, 0);
    send_pkt(K_NOLAST, 2, 2);
    send_pkt(K_EARLY, 3, 3);
    send_pkt(K_GOOD, 2, 0);
    check_stats();

    gap_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 6);
      len = $urandom_range(1, 20);
      k = $urandom_range(0, 3);
      if (kind == K_EARLY) k = $urandom_range(1, len);
      if (kind == K_NOLAST) k = $urandom_range(1, 3);
      if (kind == K_LEN)
        len = ($urandom_range(1) == 0) ? 0 : $urandom_range(381, 65535);
      send_pkt(kind, len, k);
      idle($urandom_range(0, 2));
    end
    gap_en = 1'b0;
    check_stats();

    step({16'hA5A5, 16'd5}, 1'b1, 1'b0, 6'd0, 32'd0);
    step(32'hDEAD_0001, 1'b1, 1'b0, F_V, 32'hDEAD_0001);
    step(32'hDEAD_0002, 1'b1, 1'b0, F_V, 32'hDEAD_0002);
    rst_cycles(2);
    idle(1);
    send_pkt(K_GOOD, 3, 0);
    idle(1);
    check_stats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
